vga_text_loader: RTL and testbench
==================================

Name: vga_text_loader

Overview:
- Upstream feeder for the VGA text display. Fetches two 256-character text regions from CPU data memory: the encoded text and the decoded text.
- Unpacks each 32-bit word into four bytes and collects them in shadow buffers.
- Commits both buffers atomically to the `char_data_coded` / `char_data` arrays consumed by the VGA block.
- Commit is aligned to a frame boundary so the display never tears mid-frame.

Parameters:
- ADDR_W, 32, width of memory byte address.
- CODED_BASE, 32'h0000_0400, byte base address of encoded text (256 bytes).
- DECODED_BASE, 32'h0000_0500, byte base address of decoded text (256 bytes).
- COMMIT_ON_SYNC, 1, 1 = wait for `frame_sync` before commit; 0 = commit immediately after last read.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- start  in  1  single-cycle request to reload both regions
- frame_sync  in  1  single-cycle pulse at start of vertical blank
- mem_rd  out  1  memory read strobe
- mem_addr  out  ADDR_W  word-aligned byte address (bits [1:0] always 0)
- mem_rdata  in  32  read data, valid exactly one cycle after `mem_rd`
- char_data_coded  out  8 x [255:0]  committed encoded text
- char_data  out  8 x [255:0]  committed decoded text
- busy  out  1  high in any state other than IDLE
- done  out  1  single-cycle pulse on commit

Behaviour:
- Reset (`reset == 0` at a clk edge):
  - State returns to IDLE.
  - `mem_rd = 0`, `mem_addr = 0`, `busy = 0`, `done = 0`.
  - All 512 committed and shadow bytes are set to 8'h20 (space).
  - Reset mid-operation aborts the fetch; no partial commit.
- States:
  - IDLE: `start = 1` -> READ_CODED, word counter `wc = 0`.
  - READ_CODED: `mem_rd = 1`, `mem_addr = CODED_BASE + 4*wc`; at `wc = 63` -> READ_DECODED with `wc = 0`.
  - READ_DECODED: `mem_rd = 1`, `mem_addr = DECODED_BASE + 4*wc`; at `wc = 63` -> DRAIN.
  - DRAIN: one cycle; `mem_rd = 0`; captures the final word -> WAIT_COMMIT.
  - WAIT_COMMIT: commits when `frame_sync = 1` (or unconditionally if COMMIT_ON_SYNC = 0). Outputs update at that edge, `done` is high for the following cycle, then -> IDLE.
- Timing:
  - `start` sampled high at edge t.
  - Reads issued cycles t+1 .. t+128, one per cycle, no gaps.
  - Data captured t+2 .. t+129.
  - WAIT_COMMIT entered at edge t+130.
  - With COMMIT_ON_SYNC = 0, commit occurs at edge t+131.
- Data capture and byte mapping:
  - Capture uses a 1-cycle delayed copy of (region, wc) registered alongside `mem_rd`.
  - Word w of a region, byte lane j (j = 0 is `mem_rdata[7:0]`), is byte offset i = 4w + j.
  - Byte offset i is stored at array index 255 - i, so offset 0 is displayed first (index 255).
- Boundary conditions:
  - `start` while `busy` is ignored; it is not queued.
  - `frame_sync` outside WAIT_COMMIT is ignored.
  - Committed outputs are stable at all times except the single commit edge.
  - Base parameter bits [1:0] are forced to 0.
  - Address arithmetic wraps modulo 2^ADDR_W.

Decomposition:
- Package `vga_text_pkg`:
  - Constants: `CHARS = 256`, `WORDS = 64`, `SPACE = 8'h20`.
  - State enum: `{IDLE, READ_CODED, READ_DECODED, DRAIN, WAIT_COMMIT}`.
- Sub-module `text_shadow_buffer`:
  - Instantiated twice, once per region.
  - Inputs: write enable, word index, 32-bit word, commit.
  - Function: unpacks the word into its four bytes, holds the shadow and committed arrays, and resets everything to SPACE.

Test Plan:
- Reset with `start` idle -> all 512 output bytes = 8'h20; `busy = 0`; `mem_rd = 0`.
- Memory model returns word = {8'h66, 8'h65, 8'h78, 8'h54} at CODED_BASE -> after commit:
  - `char_data_coded[255]` = 8'h54
  - `char_data_coded[254]` = 8'h78
  - `char_data_coded[253]` = 8'h65
  - `char_data_coded[252]` = 8'h66
- COMMIT_ON_SYNC = 0, start at edge t:
  - `mem_rd` high exactly 128 cycles.
  - Last address = DECODED_BASE + 252.
  - `done` high only in cycle t+131.
- COMMIT_ON_SYNC = 1, `frame_sync` held off 500 cycles after WAIT_COMMIT:
  - Outputs keep their old values until the `frame_sync` edge.
  - Outputs change and `done` pulses only after it.
- `start` pulsed again at t+40 during READ_CODED -> ignored; exactly 128 reads total; one `done`.
- `reset` asserted at t+70 mid-fetch -> IDLE next cycle; outputs all 8'h20; no `done` pulse.

Source files
------------

// File: rtl/vga_text_pkg.sv
// Shared constants and types for the VGA text loader: region sizes, FSM states
// and the byte-offset to display-index mapping.
package vga_text_pkg;

    localparam int         CHARS = 256;
    localparam int         WORDS = 64;
    localparam logic [7:0] SPACE = 8'h20;

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        READ_CODED   = 3'd1,
        READ_DECODED = 3'd2,
        DRAIN        = 3'd3,
        WAIT_COMMIT  = 3'd4
    } state_t;

    typedef enum logic {
        REGION_CODED   = 1'b0,
        REGION_DECODED = 1'b1
    } region_t;

    // Byte offset 4*word+lane lands at index 255-offset, so offset 0 shows first.
    function automatic logic [7:0] char_index(input logic [5:0] word_idx,
                                              input logic [1:0] lane);
        return 8'hFF - {word_idx, lane};
    endfunction

endpackage

// File: rtl/text_shadow_buffer.sv
// One text region: unpacks fetched words into a shadow array and copies the
// whole shadow into the committed array on a commit strobe.
module text_shadow_buffer
    import vga_text_pkg::*;
(
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_wr_en,
    input  logic [5:0]             i_word_idx,
    input  logic [31:0]            i_word,
    input  logic                   i_commit,
    output logic [CHARS-1:0][7:0]  o_chars
);

    logic [CHARS-1:0][7:0] r_shadow;
    logic [CHARS-1:0][7:0] r_committed;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_shadow    <= {CHARS{SPACE}};
            r_committed <= {CHARS{SPACE}};
        end else begin
            if (i_wr_en) begin
                for (int j = 0; j < 4; j++) begin
                    r_shadow[char_index(i_word_idx, 2'(j))] <= i_word[8*j +: 8];
                end
            end
            if (i_commit) begin
                r_committed <= r_shadow;
            end
        end
    end

    assign o_chars = r_committed;

endmodule

// File: rtl/vga_text_loader.sv
// Fetches the encoded and decoded 256-byte text regions word by word and
// commits both to the display arrays together, optionally on a frame boundary.
//
// state        | meaning
// IDLE         | waiting for start
// READ_CODED   | issuing the 64 reads of the encoded region
// READ_DECODED | issuing the 64 reads of the decoded region
// DRAIN        | reads done, waiting for the last word to be captured
// WAIT_COMMIT  | shadows full, waiting for frame_sync (or committing at once)
module vga_text_loader
    import vga_text_pkg::*;
#(
    parameter int unsigned       ADDR_W         = 32,
    parameter logic [ADDR_W-1:0] CODED_BASE     = ADDR_W'(32'h0000_0400),
    parameter logic [ADDR_W-1:0] DECODED_BASE   = ADDR_W'(32'h0000_0500),
    parameter bit                COMMIT_ON_SYNC = 1'b1
)
(
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_start,
    input  logic                   i_frame_sync,
    output logic                   o_mem_rd,
    output logic [ADDR_W-1:0]      o_mem_addr,
    input  logic [31:0]            i_mem_rdata,
    output logic [CHARS-1:0][7:0]  o_char_data_coded,
    output logic [CHARS-1:0][7:0]  o_char_data,
    output logic                   o_busy,
    output logic                   o_done
);

    localparam logic [ADDR_W-1:0] CODED_ALIGNED   = {CODED_BASE[ADDR_W-1:2], 2'b00};
    localparam logic [ADDR_W-1:0] DECODED_ALIGNED = {DECODED_BASE[ADDR_W-1:2], 2'b00};
    localparam logic [5:0]        LAST_WORD       = 6'(WORDS - 1);

    state_t            r_state;
    logic [5:0]        r_wc;
    logic              r_mem_rd;
    logic [ADDR_W-1:0] r_mem_addr;
    region_t           r_mem_region;
    logic [5:0]        r_mem_wc;
    logic              r_cap_vld;
    region_t           r_cap_region;
    logic [5:0]        r_cap_wc;
    logic              r_done;

    logic              w_commit;
    logic              w_wr_coded;
    logic              w_wr_decoded;
    logic [ADDR_W-1:0] w_word_off;

    assign w_commit   = (r_state == WAIT_COMMIT) && (!COMMIT_ON_SYNC || i_frame_sync);
    assign w_word_off = ADDR_W'({r_wc, 2'b00});

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state      <= IDLE;
            r_wc         <= '0;
            r_mem_rd     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_region <= REGION_CODED;
            r_mem_wc     <= '0;
            r_cap_vld    <= 1'b0;
            r_cap_region <= REGION_CODED;
            r_cap_wc     <= '0;
            r_done       <= 1'b0;
        end else begin
            // Capture tag trails the read strobe by one cycle, matching rdata latency.
            r_cap_vld    <= r_mem_rd;
            r_cap_region <= r_mem_region;
            r_cap_wc     <= r_mem_wc;
            r_mem_rd     <= 1'b0;
            r_done       <= w_commit;

            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_state <= READ_CODED;
                        r_wc    <= '0;
                    end
                end
                READ_CODED: begin
                    r_mem_rd     <= 1'b1;
                    r_mem_addr   <= CODED_ALIGNED + w_word_off;
                    r_mem_region <= REGION_CODED;
                    r_mem_wc     <= r_wc;
                    r_wc         <= r_wc + 6'd1;
                    if (r_wc == LAST_WORD) begin
                        r_state <= READ_DECODED;
                    end
                end
                READ_DECODED: begin
                    r_mem_rd     <= 1'b1;
                    r_mem_addr   <= DECODED_ALIGNED + w_word_off;
                    r_mem_region <= REGION_DECODED;
                    r_mem_wc     <= r_wc;
                    r_wc         <= r_wc + 6'd1;
                    if (r_wc == LAST_WORD) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Leave on the edge that captures the final word.
                    if (r_cap_vld && !r_mem_rd) begin
                        r_state <= WAIT_COMMIT;
                    end
                end
                WAIT_COMMIT: begin
                    if (w_commit) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_wr_coded   = r_cap_vld && (r_cap_region == REGION_CODED);
    assign w_wr_decoded = r_cap_vld && (r_cap_region == REGION_DECODED);

    text_shadow_buffer u_coded_buf (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_wr_en    (w_wr_coded),
        .i_word_idx (r_cap_wc),
        .i_word     (i_mem_rdata),
        .i_commit   (w_commit),
        .o_chars    (o_char_data_coded)
    );

    text_shadow_buffer u_decoded_buf (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_wr_en    (w_wr_decoded),
        .i_word_idx (r_cap_wc),
        .i_word     (i_mem_rdata),
        .i_commit   (w_commit),
        .o_chars    (o_char_data)
    );

    assign o_mem_rd   = r_mem_rd;
    assign o_mem_addr = r_mem_addr;
    assign o_busy     = (r_state != IDLE);
    assign o_done     = r_done;

endmodule

// File: tb/tb_vga_text_loader.sv
// Bench for vga_text_loader: two instances (immediate commit and frame-synced
// commit) share stimulus and are checked every cycle against a cycle-count model.
module tb_vga_text_loader;

    logic clk;
    logic rst_n;
    logic start;
    logic frame_sync;

    logic                  mem_rd   [2];
    logic [31:0]           mem_addr [2];
    logic [31:0]           rdata    [2];
    logic [255:0][7:0]     chc      [2];
    logic [255:0][7:0]     chd      [2];
    logic                  busy     [2];
    logic                  done     [2];

    logic [7:0]            tb_mem [2048];

    int n_tests;
    int n_fail;

    // model state, owned by the checker branch
    bit                m_init   [2];
    bit                m_active [2];
    bit                m_fresh  [2];
    bit                m_done   [2];
    int                m_cnt    [2];
    logic [255:0][7:0] m_coded  [2];
    logic [255:0][7:0] m_dec    [2];
    logic              s_rst, s_start, s_fs;
    bit                exp_rd;
    logic [31:0]       exp_addr;

    logic [255:0][7:0] all_space;
    int                rd_cnt, done_at, done_n0, done_n1;
    logic [31:0]       last_addr;

    vga_text_loader #(.COMMIT_ON_SYNC(1'b0)) dut0 (
        .i_clk(clk), .i_reset(rst_n), .i_start(start), .i_frame_sync(frame_sync),
        .o_mem_rd(mem_rd[0]), .o_mem_addr(mem_addr[0]), .i_mem_rdata(rdata[0]),
        .o_char_data_coded(chc[0]), .o_char_data(chd[0]),
        .o_busy(busy[0]), .o_done(done[0])
    );

    vga_text_loader #(.COMMIT_ON_SYNC(1'b1)) dut1 (
        .i_clk(clk), .i_reset(rst_n), .i_start(start), .i_frame_sync(frame_sync),
        .o_mem_rd(mem_rd[1]), .o_mem_addr(mem_addr[1]), .i_mem_rdata(rdata[1]),
        .o_char_data_coded(chc[1]), .o_char_data(chd[1]),
        .o_busy(busy[1]), .o_done(done[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [10:0] b;
        b = a[10:0];
        return {tb_mem[b + 11'd3], tb_mem[b + 11'd2], tb_mem[b + 11'd1], tb_mem[b]};
    endfunction

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (mem_rd[d]) rdata[d] <= mem_word(mem_addr[d]);
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_arr(input string name, input logic [255:0][7:0] act,
                           input logic [255:0][7:0] exp);
        int idx;
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            idx = -1;
            for (int i = 255; i >= 0; i--) begin
                if (idx < 0 && act[i] !== exp[i]) idx = i;
            end
            if (n_fail <= 40)
                $display("FAIL %s: index %0d got %0h expected %0h", name, idx,
                         act[idx], exp[idx]);
        end
    endtask

    task automatic step(input logic st, input logic fs, input logic rb);
        start      = st;
        frame_sync = fs;
        rst_n      = rb;
        @(posedge clk);
        #2;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((m_active[0] || m_active[1]) && k < 400) begin
            step(1'b0, 1'b1, 1'b1);
            k++;
        end
        n_tests++;
        if (m_active[0] || m_active[1]) begin
            n_fail++;
            $display("FAIL wait_idle: still busy after %0d cycles, required idle", k);
        end
    endtask

    // Model: a fetch is just a count of edges since the accepted start.
    // Reads are visible after edges 1..128, commit at edge 131 or the first
    // frame_sync edge from 131 on.
    task automatic checker_loop();
        forever begin
            @(posedge clk);
            s_rst = rst_n; s_start = start; s_fs = frame_sync;
            for (int d = 0; d < 2; d++) begin
                if (!s_rst) begin
                    m_init[d] = 1; m_active[d] = 0; m_fresh[d] = 1;
                    m_done[d] = 0; m_cnt[d] = 0;
                    for (int i = 0; i < 256; i++) begin
                        m_coded[d][i] = 8'h20;
                        m_dec[d][i]   = 8'h20;
                    end
                end else begin
                    m_done[d] = 0;
                    if (m_active[d]) begin
                        m_cnt[d]++;
                        if (m_cnt[d] == 1) m_fresh[d] = 0;
                        if (m_cnt[d] >= 131 && (d == 0 ? m_cnt[d] == 131 : s_fs == 1'b1)) begin
                            for (int i = 0; i < 256; i++) begin
                                m_coded[d][255 - i] = tb_mem[1024 + i];
                                m_dec[d][255 - i]   = tb_mem[1280 + i];
                            end
                            m_done[d]   = 1;
                            m_active[d] = 0;
                        end
                    end else if (s_start) begin
                        m_active[d] = 1;
                        m_cnt[d]    = 0;
                    end
                end
            end
            #1;
            for (int d = 0; d < 2; d++) begin
                if (m_init[d]) begin
                    exp_rd = m_active[d] && m_cnt[d] >= 1 && m_cnt[d] <= 128;
                    chk($sformatf("dut%0d busy", d), 64'(busy[d]), 64'(m_active[d]));
                    chk($sformatf("dut%0d mem_rd", d), 64'(mem_rd[d]), 64'(exp_rd));
                    chk($sformatf("dut%0d done", d), 64'(done[d]), 64'(m_done[d]));
                    if (exp_rd) begin
                        exp_addr = (m_cnt[d] <= 64) ? 32'h400 + 32'(4 * (m_cnt[d] - 1))
                                                    : 32'h500 + 32'(4 * (m_cnt[d] - 65));
                        chk($sformatf("dut%0d mem_addr", d), 64'(mem_addr[d]), 64'(exp_addr));
                    end else if (m_fresh[d]) begin
                        chk($sformatf("dut%0d mem_addr_rst", d), 64'(mem_addr[d]), 64'h0);
                    end
                    chk_arr($sformatf("dut%0d char_data_coded", d), chc[d], m_coded[d]);
                    chk_arr($sformatf("dut%0d char_data", d), chd[d], m_dec[d]);
                end
            end
        end
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        rst_n = 1'b0; start = 1'b0; frame_sync = 1'b0;
        for (int d = 0; d < 2; d++) begin
            m_init[d] = 0; m_active[d] = 0; m_fresh[d] = 0; m_done[d] = 0; m_cnt[d] = 0;
        end
        for (int a = 0; a < 2048; a++) tb_mem[a] = 8'($urandom);
        for (int i = 0; i < 256; i++) all_space[i] = 8'h20;

        fork
            checker_loop();
            begin
                // reset state
                step(1'b0, 1'b0, 1'b0);
                step(1'b0, 1'b0, 1'b0);
                step(1'b0, 1'b0, 1'b1);
                for (int d = 0; d < 2; d++) begin
                    chk_arr($sformatf("reset coded%0d", d), chc[d], all_space);
                    chk_arr($sformatf("reset decoded%0d", d), chd[d], all_space);
                    chk($sformatf("reset busy%0d", d), 64'(busy[d]), 64'h0);
                    chk($sformatf("reset mem_rd%0d", d), 64'(mem_rd[d]), 64'h0);
                end

                // full fetch, extra start at t+40, frame_sync held off 500 cycles
                tb_mem[1024] = 8'h54; tb_mem[1025] = 8'h78;
                tb_mem[1026] = 8'h65; tb_mem[1027] = 8'h66;
                rd_cnt = 0; done_at = -1; done_n0 = 0; done_n1 = 0; last_addr = '0;
                step(1'b1, 1'b0, 1'b1);
                for (int k = 1; k <= 630; k++) begin
                    step(k == 40, 1'b0, 1'b1);
                    if (mem_rd[0]) begin rd_cnt++; last_addr = mem_addr[0]; end
                    if (done[0]) begin done_n0++; done_at = k; end
                    if (done[1]) done_n1++;
                end
                chk("read count", 64'(rd_cnt), 64'd128);
                chk("last address", 64'(last_addr), 64'h5FC);
                chk("done cycle", 64'(done_at), 64'd131);
                chk("done pulses dut0", 64'(done_n0), 64'd1);
                chk("done before sync dut1", 64'(done_n1), 64'd0);
                chk("coded[255] dut0", 64'(chc[0][255]), 64'h54);
                chk("coded[254] dut0", 64'(chc[0][254]), 64'h78);
                chk("coded[253] dut0", 64'(chc[0][253]), 64'h65);
                chk("coded[252] dut0", 64'(chc[0][252]), 64'h66);
                chk("coded[255] dut1 held", 64'(chc[1][255]), 64'h20);
                step(1'b0, 1'b1, 1'b1);
                chk("done on sync dut1", 64'(done[1]), 64'h1);
                chk("coded[255] dut1", 64'(chc[1][255]), 64'h54);
                chk("coded[252] dut1", 64'(chc[1][252]), 64'h66);
                step(1'b0, 1'b0, 1'b1);

                // reset at t+70 aborts the fetch
                step(1'b1, 1'b0, 1'b1);
                for (int k = 1; k < 70; k++) step(1'b0, 1'b0, 1'b1);
                step(1'b0, 1'b0, 1'b0);
                for (int d = 0; d < 2; d++) begin
                    chk($sformatf("abort busy%0d", d), 64'(busy[d]), 64'h0);
                    chk($sformatf("abort mem_rd%0d", d), 64'(mem_rd[d]), 64'h0);
                    chk_arr($sformatf("abort coded%0d", d), chc[d], all_space);
                    chk_arr($sformatf("abort decoded%0d", d), chd[d], all_space);
                end
                done_n0 = 0;
                for (int k = 0; k < 200; k++) begin
                    step(1'b0, 1'($urandom_range(0, 1)), 1'b1);
                    if (done[0] || done[1]) done_n0++;
                end
                chk("no done after abort", 64'(done_n0), 64'd0);

                // randomized traffic; memory only changes while both are idle
                for (int it = 0; it < 12; it++) begin
                    wait_idle();
                    for (int a = 1024; a < 1536; a++) tb_mem[a] = 8'($urandom);
                    for (int c = 0; c < 400; c++) begin
                        step($urandom_range(0, 40) == 0, $urandom_range(0, 15) == 0,
                             $urandom_range(0, 999) != 0);
                    end
                end
                wait_idle();
                step(1'b0, 1'b0, 1'b1);

                $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
                $finish;
            end
        join_any
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

endmodule
